// File: rtl/fp_mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_arb_pkg
// Brief    : Shared types and default sizing for the FP multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fp_mult_arb_pkg;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_LAT        = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  // Wide enough for the largest supported requester count (8).
  localparam int ID_W = 3;

  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } rnd_mode_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [31:0]     z;
    logic [7:0]      status;
    logic [ID_W-1:0] id;
  } resp_t;

endpackage
`default_nettype wire

// File: rtl/fp_mult_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_arb_fifo
// Brief    : Synchronous first-word-fall-through FIFO of multiplier results.
//            The head is presented combinationally; it reads as zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_arb_fifo
  import fp_mult_arb_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  resp_t                      wr_data,
  input  logic                       pop,
  output resp_t                      rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  resp_t          mem_q [DEPTH];
  resp_t          mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push;
  logic           do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Head of queue, forced to zero when nothing is stored.
  always_comb begin
    rd_data = '0;
    if (!empty) rd_data = mem_q[rd_ptr_q];
  end

  // Pointer, occupancy and storage update; pointers wrap at DEPTH.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/fp_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_arbiter
// Brief    : Round-robin sharing of one pipelined FP multiplier among NREQ
//            requesters, with tag tracking, a result FIFO and credit control.
//            Optional macro FP_MULT_ARB_STATS_EN adds issue/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_arbiter
  import fp_mult_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int LAT        = DEF_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*32-1:0]        req_a,
  input  logic [NREQ*32-1:0]        req_b,
  input  logic [NREQ*3-1:0]         req_rnd,
  output logic [31:0]               mul_a,
  output logic [31:0]               mul_b,
  output logic [2:0]                mul_rnd,
  input  logic [31:0]               mul_z,
  input  logic [7:0]                mul_status,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_z,
  output logic [7:0]                resp_status,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic                      busy
`ifdef FP_MULT_ARB_STATS_EN
  ,
  output logic [31:0]               issue_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(LAT + FIFO_DEPTH + 2);

  // Tag stage 0 lines up with the operand register; stages 1..LAT follow the
  // multiplier's internal pipeline, so stage LAT pairs with mul_z/mul_status.
  tag_t            tag_q [LAT+1];
  tag_t            tag_d [LAT+1];
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;
  logic [2:0]      mul_rnd_q, mul_rnd_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [SW-1:0]   cand;
  logic [OW-1:0]   outstanding;
  logic            credit;
  logic            issue;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FCW-1:0]  fifo_count;
  resp_t           fifo_wr;
  resp_t           fifo_rd;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + SW'(i);
      if (cand >= SW'(NREQ)) cand = cand - SW'(NREQ);
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Credit: every in-flight tag plus every queued result holds one slot.
  always_comb begin
    outstanding = OW'(fifo_count);
    for (int i = 0; i <= LAT; i++) begin
      outstanding = outstanding + OW'(tag_q[i].valid);
    end
    credit = (outstanding < OW'(FIFO_DEPTH));
    issue  = grant_found && credit && !rst;
  end

  // One-hot grant and operand capture for the winning requester.
  always_comb begin
    req_ready = '0;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_rnd_d = mul_rnd_q;
    for (int k = 0; k < NREQ; k++) begin
      if (issue && (grant_idx == IDW'(k))) begin
        req_ready[k] = 1'b1;
        mul_a_d      = req_a[32*k +: 32];
        mul_b_d      = req_b[32*k +: 32];
        mul_rnd_d    = req_rnd[3*k +: 3];
      end
    end
  end

  // Pointer advance and tag pipe shift.
  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    tag_d[0].valid = issue;
    tag_d[0].id    = ID_W'(grant_idx);
    for (int i = 1; i <= LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Arbiter, operand and tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_rnd_q <= '0;
      for (int i = 0; i <= LAT; i++) tag_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_rnd_q <= mul_rnd_d;
      tag_q     <= tag_d;
    end
  end

  assign fifo_push      = tag_q[LAT].valid;
  assign fifo_wr.z      = mul_z;
  assign fifo_wr.status = mul_status;
  assign fifo_wr.id     = tag_q[LAT].id;
  assign fifo_pop       = resp_valid && resp_ready;

  fp_mult_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wr),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Credits make an overflowing push impossible; flag it if it ever happens.
  a_no_fifo_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full))
    else $error("result pushed into a full FIFO");

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_rnd     = mul_rnd_q;
  assign resp_valid  = !fifo_empty;
  assign resp_z      = fifo_rd.z;
  assign resp_status = fifo_rd.status;
  assign resp_id     = IDW'(fifo_rd.id);
  assign busy        = (outstanding != '0);

`ifdef FP_MULT_ARB_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Issue and credit-stall counters, free-running with natural wrap.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (issue) issue_cnt_d = issue_cnt_q + 32'd1;
    if ((|req_valid) && !issue) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mult_arbiter
// Brief    : Directed self-checking bench for fp_mult_arbiter with a fixed
//            three-stage multiplier stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mult_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*3-1:0]  req_rnd;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [2:0]         mul_rnd;
  logic [31:0]        mul_z;
  logic [7:0]         mul_status;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_z;
  logic [7:0]         resp_status;
  logic [1:0]         resp_id;
  logic               busy;
`ifdef FP_MULT_ARB_STATS_EN
  logic [31:0]        issue_cnt;
  logic [31:0]        stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  fp_mult_arbiter #(.NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rnd     (req_rnd),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_rnd     (mul_rnd),
    .mul_z       (mul_z),
    .mul_status  (mul_status),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_z      (resp_z),
    .resp_status (resp_status),
    .resp_id     (resp_id),
    .busy        (busy)
`ifdef FP_MULT_ARB_STATS_EN
    ,
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: known products for the vectors used, XOR otherwise.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40000000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40400000;
    return a ^ b;
  endfunction

  // Status = {rnd, 5'h11} so the echoed status reveals the rounding mode used.
  logic [39:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= {ref_mul(mul_a, mul_b), mul_rnd, 5'h11};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_z      = mpipe[LAT-1][39:8];
  assign mul_status = mpipe[LAT-1][7:0];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rnd);
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    req_rnd[3*k +: 3] = rnd;
  endtask

  task automatic load_all;
    for (int k = 0; k < NREQ; k++) begin
      if (k == 1) set_req(k, 32'h3FC00000, 32'h3FC00000, 3'(k));
      else        set_req(k, 32'h40400000, 32'h3F800000, 3'(k));
    end
  endtask

  task automatic do_reset;
    req_valid  = '0;
    resp_ready = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    set_req(0, 32'h12345678, 32'h9ABCDEF0, 3'd5);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    do_reset;
    #1;
    tests++; if (mul_a !== 32'h0) begin fails++; $display("FAIL reset_mul_a: got %h want 00000000", mul_a); end
    tests++; if (mul_b !== 32'h0) begin fails++; $display("FAIL reset_mul_b: got %h want 00000000", mul_b); end
    tests++; if (mul_rnd !== 3'd0) begin fails++; $display("FAIL reset_mul_rnd: got %0d want 0", mul_rnd); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests++; if (resp_z !== 32'h0 || resp_status !== 8'h0 || resp_id !== 2'd0)
      begin fails++; $display("FAIL reset_resp_fields: got z=%h st=%h id=%0d want zeros", resp_z, resp_status, resp_id); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single;
    int lat;
    do_reset;
    set_req(0, 32'h3F800000, 32'h40000000, 3'd0);
    req_valid = 4'b0001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    tests++; if (mul_a !== 32'h3F800000 || mul_b !== 32'h40000000)
      begin fails++; $display("FAIL single_operands: got a=%h b=%h want 3f800000 40000000", mul_a, mul_b); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests++; if (lat !== 4) begin fails++; $display("FAIL single_latency: got %0d want 4", lat); end
    tests++; if (resp_z !== 32'h40000000 || resp_id !== 2'd0 || resp_status !== 8'h11)
      begin fails++; $display("FAIL single_resp: got z=%h id=%0d st=%h want 40000000 0 11", resp_z, resp_id, resp_status); end
    @(negedge clk);
    tests++; if (resp_valid !== 1'b1 || resp_z !== 32'h40000000)
      begin fails++; $display("FAIL single_hold: got v=%b z=%h want 1 40000000", resp_valid, resp_z); end
    resp_ready = 1'b1;
    @(negedge clk);
    tests++; if (resp_valid !== 1'b0 || busy !== 1'b0)
      begin fails++; $display("FAIL single_drain: got v=%b busy=%b want 0 0", resp_valid, busy); end
    resp_ready = 1'b0;
  endtask

  task automatic test_contention;
    int issued, rcvd, exp_g;
    logic [31:0] ez;
    do_reset;
    load_all;
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    issued = 0; rcvd = 0; exp_g = 0;
    for (int c = 0; c < 80 && rcvd < 12; c++) begin
      #1;
      if (req_ready != '0) begin
        tests++;
        if (req_ready !== 4'(1 << exp_g)) begin
          fails++; $display("FAIL contention_grant: got %b want %b", req_ready, 4'(1 << exp_g));
        end
        exp_g = (exp_g + 1) % 4;
        issued++;
      end
      if (resp_valid) begin
        ez = (rcvd % 4 == 1) ? 32'h40100000 : 32'h40400000;
        tests++;
        if (resp_id !== 2'(rcvd % 4) || resp_z !== ez || resp_status !== {3'(rcvd % 4), 5'h11}) begin
          fails++; $display("FAIL contention_resp: got id=%0d z=%h st=%h want id=%0d z=%h st=%h",
                            resp_id, resp_z, resp_status, rcvd % 4, ez, {3'(rcvd % 4), 5'h11});
        end
        rcvd++;
      end
      @(negedge clk);
      if (issued == 12) req_valid = '0;
    end
    tests++; if (issued !== 12 || rcvd !== 12)
      begin fails++; $display("FAIL contention_counts: got issued=%0d rcvd=%0d want 12 12", issued, rcvd); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL contention_idle: got busy=%b want 0", busy); end
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int issued, rcvd;
    do_reset;
    load_all;
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready != '0) issued++;
      @(negedge clk);
    end
    #1;
    tests++; if (issued !== 4) begin fails++; $display("FAIL bp_issues: got %0d want 4", issued); end
    tests++; if (req_ready !== 4'b0000 || busy !== 1'b1 || resp_valid !== 1'b1)
      begin fails++; $display("FAIL bp_stalled: got ready=%b busy=%b v=%b want 0000 1 1", req_ready, busy, resp_valid); end
`ifdef FP_MULT_ARB_STATS_EN
    tests++; if (issue_cnt !== 32'd4 || stall_cnt !== 32'd6)
      begin fails++; $display("FAIL bp_stats: got issue=%0d stall=%0d want 4 6", issue_cnt, stall_cnt); end
`endif
    resp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_no_early_credit: got %b want 0000", req_ready); end
    tests++; if (resp_id !== 2'd0) begin fails++; $display("FAIL bp_first_id: got %0d want 0", resp_id); end
    rcvd = 1;
    @(negedge clk);
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_resume: got %b want 0001", req_ready); end
    tests++; if (resp_valid !== 1'b1 || resp_id !== 2'd1)
      begin fails++; $display("FAIL bp_second_id: got v=%b id=%0d want 1 1", resp_valid, resp_id); end
    rcvd = 2;
    @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 30 && rcvd < 5; c++) begin
      #1;
      if (resp_valid) begin
        tests++;
        if (resp_id !== 2'(rcvd % 4)) begin
          fails++; $display("FAIL bp_order: got id=%0d want %0d", resp_id, rcvd % 4);
        end
        rcvd++;
      end
      @(negedge clk);
    end
    tests++; if (rcvd !== 5 || busy !== 1'b0)
      begin fails++; $display("FAIL bp_drain: got rcvd=%0d busy=%b want 5 0", rcvd, busy); end
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight;
    int seen;
    do_reset;
    load_all;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_resp: got %0d responses want 0", seen); end
    req_valid = 4'b0101;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL midrst_ptr: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_rnd;
    int lat;
    do_reset;
    set_req(2, 32'h40400000, 32'h3F800000, 3'd3);
    req_valid = 4'b0100;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rnd_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    tests++; if (mul_rnd !== 3'd3 || mul_a !== 32'h40400000)
      begin fails++; $display("FAIL rnd_mul: got rnd=%0d a=%h want 3 40400000", mul_rnd, mul_a); end
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_status !== 8'h71 || resp_z !== 32'h40400000)
      begin fails++; $display("FAIL rnd_resp: got v=%b id=%0d st=%h z=%h want 1 2 71 40400000",
                              resp_valid, resp_id, resp_status, resp_z); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_rnd    = '0;
    resp_ready = 1'b0;
    do_reset;
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_reset_midflight;
    test_rnd;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
